dispense_actuator: RTL and testbench

- Responder end of the dispense command interface. The dispense control FSM issues a slot request; this block answers it.
- Drives one servo gate through a 50 Hz PWM output, then confirms the drop with a beam-break pill sensor on a GPIO pin.
- Returns a one-cycle acknowledge with a success flag. Retries failed drops and raises a sticky fault.
- One instance per dispenser module. It sits between the dispense control FSM and the GPIO header.

---
 rtl/dispense_actuator.sv | 209 ++++++++++++++++++++
 tb/tb_dispense_actuator.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_actuator.sv
// Dispense actuator: answers a slot request from the dispense control FSM.
// Opens a servo gate through a 50 Hz PWM, then confirms the drop with a
// debounced beam-break sensor. Failed drops are retried, and a sticky fault
// is raised when every attempt of a request fails.
//
// Handshake: req is a level held by the initiator. This block samples slot
// when it accepts req in IDLE, answers with exactly one ack cycle (ok valid
// only in that cycle), then waits in HOLDOFF until req is low before it
// accepts another request. A req that is dropped early still gets its ack.
module dispense_actuator #(
    parameter int unsigned PWM_PERIOD   = 1000000,
    parameter int unsigned PULSE_CLOSED = 50000,
    parameter int unsigned PULSE_OPEN   = 100000,
    parameter int unsigned OPEN_HOLD    = 25000000,
    parameter int unsigned DROP_TIMEOUT = 50000000,
    parameter int unsigned MAX_RETRY    = 2,
    parameter int unsigned DEBOUNCE     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] slot,
    input  logic       sensor_in,
    output logic       ack,
    output logic       ok,
    output logic       busy,
    output logic       servo_pwm,
    output logic       fault,
    output logic [1:0] last_slot,
    output logic [7:0] dispense_count,
    output logic [2:0] state_dbg
);

    localparam int unsigned TMAX = (OPEN_HOLD > DROP_TIMEOUT) ? OPEN_HOLD : DROP_TIMEOUT;
    localparam int CW = $clog2(PWM_PERIOD);
    localparam int WW = CW + 1;
    localparam int TW = $clog2(TMAX + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_OPEN    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RESP    = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic          deb_level_q, deb_level_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          deb_rise;
    logic [CW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [WW-1:0] width_q, width_d;
    logic          pwm_q, pwm_d;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [1:0]    slot_q, slot_d;
    logic [1:0]    last_slot_q, last_slot_d;
    logic          ok_q, ok_d;
    logic          fault_q, fault_d;
    logic          detect_q, detect_d;
    logic [7:0]    count_q, count_d;

    // Synchronise the raw sensor and accept a new level only after DEBOUNCE equal samples.
    always_comb begin
        sync1_d     = sensor_in;
        sync2_d     = sync1_q;
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        if (sync2_q != deb_level_q) begin
            if (deb_cnt_q == DW'(DEBOUNCE - 1)) begin
                deb_level_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        deb_rise = deb_level_d & ~deb_level_q;
    end

    // Free-running servo frame; the pulse width only changes at a frame boundary.
    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == CW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + 1'b1;
        width_d   = width_q;
        if (pwm_cnt_q == CW'(PWM_PERIOD - 1)) begin
            width_d = (state_q == S_OPEN) ? WW'(PULSE_OPEN) : WW'(PULSE_CLOSED);
        end
        pwm_d = ({1'b0, pwm_cnt_q} < width_q);
    end

    // Request sequencing: open, wait for the drop, retry or fail, respond, hold off.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_d     = retry_q;
        slot_d      = slot_q;
        last_slot_d = last_slot_q;
        ok_d        = ok_q;
        fault_d     = fault_q;
        detect_d    = detect_q;
        count_d     = count_q;
        if (((state_q == S_OPEN) || (state_q == S_WAIT)) && deb_rise) begin
            detect_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    slot_d  = slot;
                    timer_d = '0;
                    if ((slot != 2'b00) && !fault_q) begin
                        detect_d = 1'b0;
                        retry_d  = '0;
                        state_d  = S_OPEN;
                    end else begin
                        ok_d    = 1'b0;
                        state_d = S_RESP;
                    end
                end
            end
            S_OPEN: begin
                if (timer_q == TW'(OPEN_HOLD - 1)) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (detect_q) begin
                    ok_d    = 1'b1;
                    state_d = S_RESP;
                end else if (timer_q == TW'(DROP_TIMEOUT - 1)) begin
                    timer_d = '0;
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_OPEN;
                    end else begin
                        ok_d    = 1'b0;
                        fault_d = 1'b1;
                        state_d = S_RESP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                last_slot_d = slot_q;
                if (ok_q && (count_q != 8'hFF)) begin
                    count_d = count_q + 8'd1;
                end
                state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any operation and returns the gate to closed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            width_q     <= WW'(PULSE_CLOSED);
            pwm_q       <= 1'b0;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            retry_q     <= '0;
            slot_q      <= 2'b00;
            last_slot_q <= 2'b00;
            ok_q        <= 1'b0;
            fault_q     <= 1'b0;
            detect_q    <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            width_q     <= width_d;
            pwm_q       <= pwm_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            slot_q      <= slot_d;
            last_slot_q <= last_slot_d;
            ok_q        <= ok_d;
            fault_q     <= fault_d;
            detect_q    <= detect_d;
            count_q     <= count_d;
        end
    end

    assign ack            = (state_q == S_RESP);
    assign ok             = ack & ok_q;
    assign busy           = (state_q != S_IDLE);
    assign servo_pwm      = pwm_q;
    assign fault          = fault_q;
    assign last_slot      = last_slot_q;
    assign dispense_count = count_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_dispense_actuator.sv
// Bench for dispense_actuator with reduced timing parameters.
module tb_dispense_actuator;
    localparam int PWM_PERIOD = 100, PULSE_CLOSED = 5, PULSE_OPEN = 10;
    localparam int OPEN_HOLD = 200, DROP_TIMEOUT = 300, MAX_RETRY = 2, DEBOUNCE = 4;
    localparam int ATT = OPEN_HOLD + DROP_TIMEOUT;

    logic clock = 1'b0;
    logic reset, req, sensor_in;
    logic [1:0] slot;
    logic ack, ok, busy, servo_pwm, fault;
    logic [1:0] last_slot;
    logic [7:0] dispense_count;
    logic [2:0] state_dbg;

    int errors = 0, checks = 0, cyc = 0, ack_total = 0, run_len = 0;
    int runs_q[$], rise_q[$], ev_at_q[$], ev_len_q[$];
    logic pwm_prev = 1'b0;
    int exp_count = 0, exp_last = 0, exp_fault = 0;

    dispense_actuator #(
        .PWM_PERIOD(PWM_PERIOD), .PULSE_CLOSED(PULSE_CLOSED), .PULSE_OPEN(PULSE_OPEN),
        .OPEN_HOLD(OPEN_HOLD), .DROP_TIMEOUT(DROP_TIMEOUT), .MAX_RETRY(MAX_RETRY),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .slot(slot), .sensor_in(sensor_in),
        .ack(ack), .ok(ok), .busy(busy), .servo_pwm(servo_pwm), .fault(fault),
        .last_slot(last_slot), .dispense_count(dispense_count), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // PWM pulse widths, rising-edge times and ack pulses, sampled on the falling edge.
    always @(negedge clock) begin
        cyc++;
        if (ack === 1'b1) ack_total++;
        if (servo_pwm === 1'b1) begin
            if (!pwm_prev) rise_q.push_back(cyc);
            run_len++;
        end else if (run_len > 0) begin
            runs_q.push_back(run_len);
            run_len = 0;
        end
        pwm_prev = servo_pwm;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    // Plays the scheduled sensor pulses; times are in falling edges from request start.
    task automatic drive_sensor();
        int now = 0;
        while (ev_at_q.size() > 0) begin
            int at, len;
            at = ev_at_q.pop_front();
            len = ev_len_q.pop_front();
            repeat (at - now) @(negedge clock);
            sensor_in = 1'b1;
            repeat (len) @(negedge clock);
            sensor_in = 1'b0;
            now = at + len;
        end
    endtask

    // Raises req with slot s and observes the response (no checking here).
    task automatic run_request(input logic [1:0] s, input int budget, input bit drop_early,
                               output int ack_cyc, output logic ack_ok, output int n_acks,
                               output logic busy1);
        int post = 0;
        ack_cyc = -1; ack_ok = 1'b0; n_acks = 0; busy1 = 1'b0;
        req = 1'b1; slot = s;
        fork
            drive_sensor();
            begin
                for (int c = 1; c <= budget; c++) begin
                    @(negedge clock);
                    if (c == 1) busy1 = busy;
                    if (c == 3) slot = 2'($urandom_range(0, 3));
                    if (drop_early && c == 20) req = 1'b0;
                    if (ack === 1'b1) begin
                        if (n_acks == 0) begin ack_cyc = c; ack_ok = ok; end
                        n_acks++;
                    end
                    if (n_acks > 0) begin post++; if (post > 3) break; end
                end
            end
        join
        req = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; slot = 2'b00; sensor_in = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b expected 0", ok); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (servo_pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b expected 0", servo_pwm); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
        checks++; if (last_slot !== 2'b00) begin errors++; $display("FAIL reset_last_slot: got %0d expected 0", last_slot); end
        checks++; if (dispense_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", dispense_count); end
        reset = 1'b0;
    endtask

    task automatic test_idle_pwm();
        int acks0 = ack_total;
        runs_q.delete(); rise_q.delete();
        repeat (350) @(negedge clock);
        checks++; if (rise_q.size() < 3) begin errors++; $display("FAIL idle_frames: got %0d expected >=3", rise_q.size()); end
        foreach (runs_q[i]) begin
            checks++; if (runs_q[i] != PULSE_CLOSED) begin errors++; $display("FAIL idle_width: got %0d expected %0d", runs_q[i], PULSE_CLOSED); end
        end
        for (int i = 1; i < rise_q.size(); i++) begin
            checks++; if (rise_q[i] - rise_q[i-1] != PWM_PERIOD) begin errors++; $display("FAIL idle_period: got %0d expected %0d", rise_q[i] - rise_q[i-1], PWM_PERIOD); end
        end
        checks++; if (ack_total != acks0) begin errors++; $display("FAIL idle_no_ack: got %0d expected %0d", ack_total, acks0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_success();
        int ac, n, tens = 0, others = 0; logic ao, b1;
        runs_q.delete();
        ev_at_q.push_back(OPEN_HOLD + 1 + 50); ev_len_q.push_back(10);
        run_request(2'b01, 1700, 1'b0, ac, ao, n, b1);
        exp_count++; exp_last = 1;
        foreach (runs_q[i]) begin
            if (runs_q[i] == PULSE_OPEN) tens++;
            else if (runs_q[i] != PULSE_CLOSED) others++;
        end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL success_busy_rise: got %b expected 1", b1); end
        checks++; if (n != 1) begin errors++; $display("FAIL success_ack_count: got %0d expected 1", n); end
        checks++; if (ao !== 1'b1) begin errors++; $display("FAIL success_ok: got %b expected 1", ao); end
        checks++; if (ac < 257 || ac > 260) begin errors++; $display("FAIL success_ack_time: got %0d expected 257..260", ac); end
        checks++; if (last_slot !== 2'(exp_last)) begin errors++; $display("FAIL success_last_slot: got %0d expected %0d", last_slot, exp_last); end
        checks++; if (dispense_count !== 8'(exp_count)) begin errors++; $display("FAIL success_count: got %0d expected %0d", dispense_count, exp_count); end
        checks++; if (tens < 1) begin errors++; $display("FAIL success_open_width: got %0d open frames expected >=1", tens); end
        checks++; if (others != 0) begin errors++; $display("FAIL success_bad_width: got %0d odd frames expected 0", others); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL success_idle_after: got busy %b expected 0", busy); end
    endtask

    task automatic test_invalid();
        int ac, n, bad = 0; logic ao, b1;
        runs_q.delete();
        run_request(2'b00, 20, 1'b0, ac, ao, n, b1);
        exp_last = 0;
        repeat (200) @(negedge clock);
        foreach (runs_q[i]) if (runs_q[i] != PULSE_CLOSED) bad++;
        checks++; if (n != 1) begin errors++; $display("FAIL invalid_ack_count: got %0d expected 1", n); end
        checks++; if (ac < 1 || ac > 2) begin errors++; $display("FAIL invalid_ack_time: got %0d expected 1..2", ac); end
        checks++; if (ao !== 1'b0) begin errors++; $display("FAIL invalid_ok: got %b expected 0", ao); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL invalid_fault: got %b expected 0", fault); end
        checks++; if (runs_q.size() < 1 || bad != 0) begin errors++; $display("FAIL invalid_servo: got %0d frames %0d non-closed expected closed only", runs_q.size(), bad); end
        checks++; if (dispense_count !== 8'(exp_count)) begin errors++; $display("FAIL invalid_count: got %0d expected %0d", dispense_count, exp_count); end
        checks++; if (last_slot !== 2'(exp_last)) begin errors++; $display("FAIL invalid_last_slot: got %0d expected %0d", last_slot, exp_last); end
    endtask

    // A 3-cycle glitch in the first wait is ignored; a 6-cycle pulse in the retry is accepted.
    // req is also dropped early here, which must not cancel the operation.
    task automatic test_glitch_retry();
        int ac, n, at; logic ao, b1;
        at = OPEN_HOLD + 1 + ATT + 60;
        ev_at_q.push_back(OPEN_HOLD + 1 + 40); ev_len_q.push_back(DEBOUNCE - 1);
        ev_at_q.push_back(at); ev_len_q.push_back(6);
        run_request(2'b10, 1700, 1'b1, ac, ao, n, b1);
        exp_count++; exp_last = 2;
        checks++; if (n != 1) begin errors++; $display("FAIL glitch_ack_count: got %0d expected 1", n); end
        checks++; if (ao !== 1'b1) begin errors++; $display("FAIL glitch_ok: got %b expected 1", ao); end
        checks++; if (ac < at + 2 + DEBOUNCE || ac > at + 2 + DEBOUNCE + 3) begin errors++; $display("FAIL glitch_ack_time: got %0d expected %0d..%0d", ac, at + 6, at + 9); end
        checks++; if (dispense_count !== 8'(exp_count)) begin errors++; $display("FAIL glitch_count: got %0d expected %0d", dispense_count, exp_count); end
        checks++; if (last_slot !== 2'(exp_last)) begin errors++; $display("FAIL glitch_last_slot: got %0d expected %0d", last_slot, exp_last); end
    endtask

    // Sensor already high when the request starts: only a later rising edge counts.
    task automatic test_sensor_high_start();
        int ac, n, at; logic ao, b1;
        sensor_in = 1'b1;
        repeat (20) @(negedge clock);
        at = OPEN_HOLD + 1 + ATT + 30;
        ev_at_q.push_back(OPEN_HOLD + 1 + 20); ev_len_q.push_back(10);
        ev_at_q.push_back(at); ev_len_q.push_back(8);
        run_request(2'b11, 1700, 1'b0, ac, ao, n, b1);
        exp_count++; exp_last = 3;
        checks++; if (ac < at + 6 || ac > at + 9) begin errors++; $display("FAIL high_start_ack_time: got %0d expected %0d..%0d", ac, at + 6, at + 9); end
        checks++; if (ao !== 1'b1) begin errors++; $display("FAIL high_start_ok: got %b expected 1", ao); end
        checks++; if (dispense_count !== 8'(exp_count)) begin errors++; $display("FAIL high_start_count: got %0d expected %0d", dispense_count, exp_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [1:0] s; int k, lo, hi, at, n, ac; logic ao, b1; bit drop, exp_ok;
            s = 2'($urandom_range(0, 3));
            drop = ($urandom_range(0, 3) == 0);
            ev_at_q.delete(); ev_len_q.delete();
            if (s == 2'b00) begin
                exp_ok = 1'b0; lo = 1; hi = 2;
            end else begin
                k = $urandom_range(0, MAX_RETRY);
                for (int j = 0; j < k; j++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        ev_at_q.push_back(OPEN_HOLD + 1 + j * ATT + $urandom_range(10, 250));
                        ev_len_q.push_back($urandom_range(1, DEBOUNCE - 1));
                    end
                end
                if ($urandom_range(0, 1) == 1) begin
                    at = 1 + k * ATT + $urandom_range(10, 150);
                    lo = k * ATT + OPEN_HOLD + 1; hi = lo + 2;
                end else begin
                    at = 1 + k * ATT + OPEN_HOLD + $urandom_range(5, 250);
                    lo = at + 2 + DEBOUNCE; hi = lo + 3;
                end
                ev_at_q.push_back(at); ev_len_q.push_back($urandom_range(6, 20));
                exp_ok = 1'b1;
            end
            exp_last = s;
            if (exp_ok && exp_count < 255) exp_count++;
            run_request(s, 1700, drop, ac, ao, n, b1);
            checks++; if (n != 1) begin errors++; $display("FAIL random%0d_ack_count: got %0d expected 1", i, n); end
            checks++; if (ao !== exp_ok) begin errors++; $display("FAIL random%0d_ok: got %b expected %b", i, ao, exp_ok); end
            checks++; if (ac < lo || ac > hi) begin errors++; $display("FAIL random%0d_ack_time: got %0d expected %0d..%0d", i, ac, lo, hi); end
            checks++; if (last_slot !== 2'(exp_last)) begin errors++; $display("FAIL random%0d_last_slot: got %0d expected %0d", i, last_slot, exp_last); end
            checks++; if (dispense_count !== 8'(exp_count)) begin errors++; $display("FAIL random%0d_count: got %0d expected %0d", i, dispense_count, exp_count); end
        end
    endtask

    task automatic test_fault();
        int ac, n, lo, bad = 0; logic ao, b1;
        lo = (MAX_RETRY + 1) * ATT;
        ev_at_q.delete(); ev_len_q.delete();
        run_request(2'b11, 1700, 1'b0, ac, ao, n, b1);
        exp_fault = 1; exp_last = 3;
        checks++; if (ac < lo || ac > lo + 2) begin errors++; $display("FAIL fault_ack_time: got %0d expected %0d..%0d", ac, lo, lo + 2); end
        checks++; if (ao !== 1'b0) begin errors++; $display("FAIL fault_ok: got %b expected 0", ao); end
        checks++; if (fault !== 1'(exp_fault)) begin errors++; $display("FAIL fault_set: got %b expected %0d", fault, exp_fault); end
        checks++; if (dispense_count !== 8'(exp_count)) begin errors++; $display("FAIL fault_count: got %0d expected %0d", dispense_count, exp_count); end
        runs_q.delete();
        ev_at_q.push_back(5); ev_len_q.push_back(10);
        run_request(2'b01, 20, 1'b0, ac, ao, n, b1);
        exp_last = 1;
        repeat (200) @(negedge clock);
        foreach (runs_q[i]) if (runs_q[i] != PULSE_CLOSED) bad++;
        checks++; if (ac < 1 || ac > 2) begin errors++; $display("FAIL fault_second_ack_time: got %0d expected 1..2", ac); end
        checks++; if (ao !== 1'b0) begin errors++; $display("FAIL fault_second_ok: got %b expected 0", ao); end
        checks++; if (runs_q.size() < 1 || bad != 0) begin errors++; $display("FAIL fault_second_servo: got %0d frames %0d non-closed expected closed only", runs_q.size(), bad); end
        checks++; if (fault !== 1'(exp_fault)) begin errors++; $display("FAIL fault_sticky: got %b expected %0d", fault, exp_fault); end
        checks++; if (last_slot !== 2'(exp_last)) begin errors++; $display("FAIL fault_last_slot: got %0d expected %0d", last_slot, exp_last); end
    endtask

    task automatic test_reset_mid_open();
        int ac, n, acks0, tens = 0; logic ao, b1;
        req = 1'b1; slot = 2'b01;
        repeat (50) @(negedge clock);
        reset = 1'b1;
        #1;
        acks0 = ack_total;
        checks++; if (servo_pwm !== 1'b0) begin errors++; $display("FAIL midreset_pwm: got %b expected 0", servo_pwm); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL midreset_fault_clear: got %b expected 0", fault); end
        repeat (3) @(negedge clock);
        checks++; if (ack_total != acks0) begin errors++; $display("FAIL midreset_no_ack: got %0d expected %0d", ack_total, acks0); end
        reset = 1'b0;
        exp_count = 0; exp_fault = 0;
        runs_q.delete();
        ev_at_q.push_back(30); ev_len_q.push_back(8);
        run_request(2'b01, 400, 1'b0, ac, ao, n, b1);
        exp_count = 1; exp_last = 1;
        foreach (runs_q[i]) if (runs_q[i] == PULSE_OPEN) tens++;
        checks++; if (runs_q.size() < 1 || runs_q[0] != PULSE_CLOSED) begin errors++; $display("FAIL midreset_first_frame: got %0d expected %0d", (runs_q.size() > 0) ? runs_q[0] : -1, PULSE_CLOSED); end
        checks++; if (tens < 1) begin errors++; $display("FAIL midreset_reopen: got %0d open frames expected >=1", tens); end
        checks++; if (ac < OPEN_HOLD + 1 || ac > OPEN_HOLD + 3) begin errors++; $display("FAIL midreset_ack_time: got %0d expected %0d..%0d", ac, OPEN_HOLD + 1, OPEN_HOLD + 3); end
        checks++; if (ao !== 1'b1) begin errors++; $display("FAIL midreset_ok: got %b expected 1", ao); end
        checks++; if (dispense_count !== 8'(exp_count)) begin errors++; $display("FAIL midreset_count: got %0d expected %0d", dispense_count, exp_count); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) begin
            int ac, n; logic ao, b1;
            ev_at_q.push_back(11); ev_len_q.push_back(6);
            run_request(2'($urandom_range(1, 3)), 400, 1'b0, ac, ao, n, b1);
            if (exp_count < 255) exp_count++;
            checks++; if (ao !== 1'b1) begin errors++; $display("FAIL sat%0d_ok: got %b expected 1", i, ao); end
            checks++; if (dispense_count !== 8'(exp_count)) begin errors++; $display("FAIL sat%0d_count: got %0d expected %0d", i, dispense_count, exp_count); end
        end
        checks++; if (dispense_count !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d expected 255", dispense_count); end
    endtask

    initial begin
        test_reset();
        test_idle_pwm();
        test_success();
        test_invalid();
        test_glitch_retry();
        test_sensor_high_start();
        test_random();
        test_fault();
        test_reset_mid_open();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
